vga_out_pipe: RTL and testbench

VGA_OUT_PIPE -- requirements
Module: vga_out_pipe

---
 rtl/vga_pkg.sv | 12 +
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_out_pipe.sv | 115 +++++++++++
 tb/tb_vga_out_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared mode encodings and default widths for the VGA output pipeline.
package vga_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_FILL  = 2'd2;
    localparam logic [1:0] MODE_BLACK = 2'd3;

    localparam int DEFAULT_CW  = 4;
    localparam int DEFAULT_XYW = 11;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay for a packed bus; every stage resets to RESET_VAL.
module vga_delay_line #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             VGA_CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge VGA_CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_out_pipe.sv
// VGA output stage: visibility gating, frame-synchronous mode select and
// test-pattern generation, followed by an aligned delay of colour and syncs.
module vga_out_pipe
    import vga_pkg::*;
#(
    parameter int CW        = DEFAULT_CW,
    parameter int XYW       = DEFAULT_XYW,
    parameter int LAT       = 2,
    parameter int H_START   = 1,
    parameter int V_START   = 1,
    parameter int BAR_SHIFT = 6
) (
    input  logic           VGA_CLK,
    input  logic           RESET,
    input  logic           SYNC_COLOR,
    input  logic [XYW-1:0] Current_X,
    input  logic [XYW-1:0] Current_Y,
    input  logic [CW-1:0]  iVGA_R,
    input  logic [CW-1:0]  iVGA_G,
    input  logic [CW-1:0]  iVGA_B,
    input  logic           iHS,
    input  logic           iVS,
    input  logic [1:0]     MODE,
    input  logic [CW-1:0]  FILL_R,
    input  logic [CW-1:0]  FILL_G,
    input  logic [CW-1:0]  FILL_B,
    output logic [CW-1:0]  oVGA_R,
    output logic [CW-1:0]  oVGA_G,
    output logic [CW-1:0]  oVGA_B,
    output logic           oHS,
    output logic           oVS,
    output logic           oBLANK_N,
    output logic [1:0]     MODE_ACT
);

    localparam int             BW         = 3*CW + 3;
    localparam logic [XYW-1:0] H_START_V  = XYW'(H_START);
    localparam logic [XYW-1:0] V_START_V  = XYW'(V_START);
    // Bus order {R, G, B, HS, VS, BLANK_N}; idle means syncs high, blanked.
    localparam logic [BW-1:0]  PIPE_IDLE  = {{(3*CW){1'b0}}, 3'b110};

    logic          vs_hist;
    logic [1:0]    mode_act;
    logic          vs_fall;
    logic          visible;
    logic [1:0]    mode_sel;
    logic [2:0]    bar_idx;
    logic [CW-1:0] nxt_r, nxt_g, nxt_b;
    logic [BW-1:0] s1;
    logic [BW-1:0] pipe_out;

    always_comb begin
        vs_fall  = vs_hist & ~iVS;
        // A mode loaded on the sync edge already governs that cycle's pixel.
        mode_sel = vs_fall ? MODE : mode_act;
        visible  = SYNC_COLOR && (Current_X >= H_START_V) && (Current_Y >= V_START_V);
        bar_idx  = 3'(Current_X >> BAR_SHIFT);
        nxt_r    = '0;
        nxt_g    = '0;
        nxt_b    = '0;
        if (visible) begin
            case (mode_sel)
                MODE_PASS: begin
                    nxt_r = iVGA_R;
                    nxt_g = iVGA_G;
                    nxt_b = iVGA_B;
                end
                MODE_BARS: begin
                    nxt_r = {CW{bar_idx[2]}};
                    nxt_g = {CW{bar_idx[1]}};
                    nxt_b = {CW{bar_idx[0]}};
                end
                MODE_FILL: begin
                    nxt_r = FILL_R;
                    nxt_g = FILL_G;
                    nxt_b = FILL_B;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge VGA_CLK or negedge RESET) begin
        if (!RESET) begin
            vs_hist  <= 1'b1;
            mode_act <= MODE_PASS;
            s1       <= PIPE_IDLE;
        end else begin
            vs_hist <= iVS;
            if (vs_fall) mode_act <= MODE;
            s1 <= {nxt_r, nxt_g, nxt_b, iHS, iVS, visible};
        end
    end

    generate
        if (LAT > 1) begin : g_delay
            vga_delay_line #(
                .WIDTH     (BW),
                .DEPTH     (LAT-1),
                .RESET_VAL (PIPE_IDLE)
            ) u_delay (
                .VGA_CLK (VGA_CLK),
                .RESET   (RESET),
                .d       (s1),
                .q       (pipe_out)
            );
        end else begin : g_nodelay
            assign pipe_out = s1;
        end
    endgenerate

    assign {oVGA_R, oVGA_G, oVGA_B, oHS, oVS, oBLANK_N} = pipe_out;
    assign MODE_ACT = mode_act;

endmodule

// File: tb/tb_vga_out_pipe.sv
// Directed bench for vga_out_pipe at LAT=1, 2 and 4 driven from shared inputs.
module tb_vga_out_pipe;
    import vga_pkg::*;

    localparam int CW  = 4;
    localparam int XYW = 11;
    localparam int LATS [3] = '{1, 2, 4};

    logic           VGA_CLK = 1'b0;
    logic           RESET   = 1'b0;
    logic           SYNC_COLOR;
    logic [XYW-1:0] Current_X, Current_Y;
    logic [CW-1:0]  iVGA_R, iVGA_G, iVGA_B;
    logic [CW-1:0]  FILL_R, FILL_G, FILL_B;
    logic           iHS, iVS;
    logic [1:0]     MODE;

    logic [CW-1:0]  r_o [3];
    logic [CW-1:0]  g_o [3];
    logic [CW-1:0]  b_o [3];
    logic           hs_o [3];
    logic           vs_o [3];
    logic           bl_o [3];
    logic [1:0]     ma_o [3];

    int n_chk = 0;
    int n_err = 0;

    logic [XYW-1:0] bar_x   [6] = '{11'd64, 11'd128, 11'd320, 11'd448, 11'd512, 11'd2047};
    logic [2:0]     bar_idx [6] = '{3'b001, 3'b010,  3'b101,  3'b111,  3'b000,  3'b111};

    always #5 VGA_CLK = ~VGA_CLK;

    vga_out_pipe #(.LAT(1)) u_lat1 (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .SYNC_COLOR(SYNC_COLOR),
        .Current_X(Current_X), .Current_Y(Current_Y),
        .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B), .iHS(iHS), .iVS(iVS),
        .MODE(MODE), .FILL_R(FILL_R), .FILL_G(FILL_G), .FILL_B(FILL_B),
        .oVGA_R(r_o[0]), .oVGA_G(g_o[0]), .oVGA_B(b_o[0]),
        .oHS(hs_o[0]), .oVS(vs_o[0]), .oBLANK_N(bl_o[0]), .MODE_ACT(ma_o[0]));

    vga_out_pipe #(.LAT(2)) u_lat2 (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .SYNC_COLOR(SYNC_COLOR),
        .Current_X(Current_X), .Current_Y(Current_Y),
        .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B), .iHS(iHS), .iVS(iVS),
        .MODE(MODE), .FILL_R(FILL_R), .FILL_G(FILL_G), .FILL_B(FILL_B),
        .oVGA_R(r_o[1]), .oVGA_G(g_o[1]), .oVGA_B(b_o[1]),
        .oHS(hs_o[1]), .oVS(vs_o[1]), .oBLANK_N(bl_o[1]), .MODE_ACT(ma_o[1]));

    vga_out_pipe #(.LAT(4)) u_lat4 (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .SYNC_COLOR(SYNC_COLOR),
        .Current_X(Current_X), .Current_Y(Current_Y),
        .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B), .iHS(iHS), .iVS(iVS),
        .MODE(MODE), .FILL_R(FILL_R), .FILL_G(FILL_G), .FILL_B(FILL_B),
        .oVGA_R(r_o[2]), .oVGA_G(g_o[2]), .oVGA_B(b_o[2]),
        .oHS(hs_o[2]), .oVS(vs_o[2]), .oBLANK_N(bl_o[2]), .MODE_ACT(ma_o[2]));

    function automatic logic [31:0] pk(input logic [3:0] r, input logic [3:0] g,
                                       input logic [3:0] b, input logic hs,
                                       input logic vs, input logic bl);
        return 32'({r, g, b, hs, vs, bl});
    endfunction

    function automatic logic [31:0] out_of(input int k);
        return 32'({r_o[k], g_o[k], b_o[k], hs_o[k], vs_o[k], bl_o[k]});
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] exp);
        for (int k = 0; k < 3; k++) chk($sformatf("%s_lat%0d", tag, LATS[k]), out_of(k), exp);
    endtask

    task automatic chk_mode(input string tag, input logic [1:0] exp);
        for (int k = 0; k < 3; k++) chk($sformatf("%s_lat%0d", tag, LATS[k]), 32'(ma_o[k]), 32'(exp));
    endtask

    task automatic drv(input logic s, input logic [XYW-1:0] x, input logic [XYW-1:0] y,
                       input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                       input logic hs, input logic vs);
        SYNC_COLOR = s;
        Current_X  = x;
        Current_Y  = y;
        iVGA_R     = r;
        iVGA_G     = g;
        iVGA_B     = b;
        iHS        = hs;
        iVS        = vs;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge VGA_CLK);
    endtask

    logic [31:0] rst_val;
    logic [31:0] pix_a, pix_b;

    initial begin
        rst_val = pk(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        MODE = MODE_PASS;
        FILL_R = 4'h0; FILL_G = 4'h0; FILL_B = 4'h0;
        drv(1'b0, 11'd0, 11'd0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);

        // Reset held while inputs wander
        for (int i = 0; i < 6; i++) begin
            @(negedge VGA_CLK);
            drv(1'($urandom), XYW'($urandom), XYW'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            MODE = 2'($urandom);
            FILL_R = 4'($urandom);
            #2;
            chk_all($sformatf("rst_hold%0d", i), rst_val);
            chk_mode($sformatf("rst_mode%0d", i), MODE_PASS);
        end

        // Release, first visible pixel emerges after LAT cycles
        @(negedge VGA_CLK);
        RESET = 1'b1;
        MODE = MODE_PASS;
        FILL_R = 4'h0;
        drv(1'b1, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b1);
        pix_a = pk(4'hA, 4'h5, 4'h3, 1'b1, 1'b1, 1'b1);
        hold(1); chk("rel_lat2_c1", out_of(1), rst_val);
        hold(1); chk("rel_lat2_c2", out_of(1), pix_a);
        hold(1); chk("rel_lat4_c3", out_of(2), rst_val);
        hold(1); chk("rel_lat4_c4", out_of(2), pix_a);
        chk_all("pass_a53", pix_a);

        drv(1'b1, 11'd0, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b1);
        hold(4); chk_all("x0_blank", pk(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0));
        drv(1'b1, 11'd5, 11'd0, 4'hA, 4'h5, 4'h3, 1'b1, 1'b1);
        hold(4); chk_all("y0_blank", pk(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0));
        drv(1'b0, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b1);
        hold(4); chk_all("sync0_blank", pk(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0));

        // Mode request mid-frame waits for the VS falling edge
        MODE = MODE_FILL;
        FILL_R = 4'hC; FILL_G = 4'h6; FILL_B = 4'h9;
        drv(1'b1, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b1);
        hold(4);
        chk_mode("defer_mode", MODE_PASS);
        chk_all("defer_pass", pix_a);
        drv(1'b1, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b0);
        hold(1);
        chk("fill_edge_mode", 32'(ma_o[0]), 32'(MODE_FILL));
        chk("fill_edge_lat1", out_of(0), pk(4'hC, 4'h6, 4'h9, 1'b1, 1'b0, 1'b1));
        hold(3);
        chk_all("fill", pk(4'hC, 4'h6, 4'h9, 1'b1, 1'b0, 1'b1));

        MODE = MODE_BARS;
        drv(1'b1, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b1);
        hold(4);
        chk_mode("bars_defer_mode", MODE_FILL);
        chk_all("bars_defer", pk(4'hC, 4'h6, 4'h9, 1'b1, 1'b1, 1'b1));

        // Test bars
        drv(1'b1, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b0);
        hold(4);
        chk_mode("bars_mode", MODE_BARS);
        chk_all("bars_x5", pk(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1));
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, bar_x[i], 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b0);
            hold(4);
            chk_all($sformatf("bars_x%0d", bar_x[i]),
                    pk({4{bar_idx[i][2]}}, {4{bar_idx[i][1]}}, {4{bar_idx[i][0]}}, 1'b1, 1'b0, 1'b1));
        end
        drv(1'b0, 11'd448, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b0);
        hold(4); chk_all("bars_hidden", pk(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0));

        // Black mode keeps blanking behaviour
        MODE = MODE_BLACK;
        drv(1'b1, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b1);
        hold(2);
        drv(1'b1, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b0);
        hold(4);
        chk_mode("black_mode", MODE_BLACK);
        chk_all("black_vis", pk(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1));
        drv(1'b0, 11'd5, 11'd5, 4'hA, 4'h5, 4'h3, 1'b1, 1'b0);
        hold(4); chk_all("black_hidden", pk(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0));

        // Back to pass mode, then a one-cycle pulse on every field
        MODE = MODE_PASS;
        drv(1'b1, 11'd5, 11'd5, 4'h1, 4'h2, 4'h3, 1'b1, 1'b1);
        hold(2);
        drv(1'b1, 11'd5, 11'd5, 4'h1, 4'h2, 4'h3, 1'b1, 1'b0);
        hold(2);
        drv(1'b1, 11'd5, 11'd5, 4'h1, 4'h2, 4'h3, 1'b1, 1'b1);
        hold(4);
        pix_a = pk(4'h1, 4'h2, 4'h3, 1'b1, 1'b1, 1'b1);
        pix_b = pk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk_mode("pass_again_mode", MODE_PASS);
        chk_all("align_base", pix_a);
        drv(1'b0, 11'd5, 11'd5, 4'hE, 4'hD, 4'hC, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            hold(1);
            for (int k = 0; k < 3; k++)
                chk($sformatf("align_c%0d_lat%0d", c, LATS[k]), out_of(k),
                    (c == LATS[k]) ? pix_b : pix_a);
            if (c == 1) drv(1'b1, 11'd5, 11'd5, 4'h1, 4'h2, 4'h3, 1'b1, 1'b1);
        end

        // Reset asserted mid-line in bar mode
        MODE = MODE_BARS;
        drv(1'b1, 11'd448, 11'd5, 4'h7, 4'h8, 4'h9, 1'b1, 1'b0);
        hold(4);
        chk_all("bars_pre_rst", pk(4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1));
        #3 RESET = 1'b0;
        #1;
        chk_all("rst_mid", rst_val);
        chk_mode("rst_mid_mode", MODE_PASS);
        @(negedge VGA_CLK);
        drv(1'b1, 11'd448, 11'd5, 4'h7, 4'h8, 4'h9, 1'b1, 1'b1);
        RESET = 1'b1;
        hold(4);
        chk_mode("post_rst_mode", MODE_PASS);
        chk_all("post_rst_pass", pk(4'h7, 4'h8, 4'h9, 1'b1, 1'b1, 1'b1));
        drv(1'b1, 11'd448, 11'd5, 4'h7, 4'h8, 4'h9, 1'b1, 1'b0);
        hold(4);
        chk_mode("post_rst_bars_mode", MODE_BARS);
        chk_all("post_rst_bars", pk(4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
